// File: rtl/pong_sound_pkg.sv
// Shared sound IDs, note table and lookup helpers for the Pong sound sequencer.
// Sound IDs are ordered so that a numerically larger ID has higher priority.
package pong_sound_pkg;

  typedef enum logic [1:0] {
    SndNone   = 2'd0,
    SndWall   = 2'd1,
    SndPaddle = 2'd2,
    SndScore  = 2'd3
  } sound_e;

  localparam int unsigned NoteBits = 20;
  localparam int unsigned DurBits  = 8;

  localparam logic [NoteBits-1:0] WallHalf    = 20'd113636;
  localparam logic [NoteBits-1:0] PaddleHalf  = 20'd56818;
  localparam logic [NoteBits-1:0] ScoreHalf0  = 20'd56818;
  localparam logic [NoteBits-1:0] ScoreHalf1  = 20'd45126;
  localparam logic [NoteBits-1:0] ScoreHalf2  = 20'd37936;
  localparam logic [DurBits-1:0]  WallDur     = 8'd10;
  localparam logic [DurBits-1:0]  PaddleDur   = 8'd10;
  localparam logic [DurBits-1:0]  ScoreDur    = 8'd15;

  localparam logic [1:0] WallNotes   = 2'd1;
  localparam logic [1:0] PaddleNotes = 2'd1;
  localparam logic [1:0] ScoreNotes  = 2'd3;

  function automatic logic [NoteBits-1:0] note_half(sound_e snd, logic [1:0] idx);
    logic [NoteBits-1:0] h;
    h = '0;
    case (snd)
      SndWall:   h = WallHalf;
      SndPaddle: h = PaddleHalf;
      SndScore: begin
        case (idx)
          2'd0:    h = ScoreHalf0;
          2'd1:    h = ScoreHalf1;
          2'd2:    h = ScoreHalf2;
          default: h = '0;
        endcase
      end
      default:   h = '0;
    endcase
    return h;
  endfunction

  function automatic logic [DurBits-1:0] note_dur(sound_e snd);
    logic [DurBits-1:0] d;
    case (snd)
      SndWall:   d = WallDur;
      SndPaddle: d = PaddleDur;
      SndScore:  d = ScoreDur;
      default:   d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] note_count(sound_e snd);
    logic [1:0] n;
    case (snd)
      SndWall:   n = WallNotes;
      SndPaddle: n = PaddleNotes;
      SndScore:  n = ScoreNotes;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

  // Request/pending vectors use bit0 = wall, bit1 = paddle, bit2 = score.
  function automatic sound_e pick_highest(logic [2:0] m);
    sound_e s;
    if (m[2])      s = SndScore;
    else if (m[1]) s = SndPaddle;
    else if (m[0]) s = SndWall;
    else           s = SndNone;
    return s;
  endfunction

  function automatic logic [2:0] sound_mask(sound_e snd);
    logic [2:0] m;
    case (snd)
      SndWall:   m = 3'b001;
      SndPaddle: m = 3'b010;
      SndScore:  m = 3'b100;
      default:   m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pong_sound_sequencer_if.sv
// Game-event requests in, tone-generator controls out.
interface pong_sound_sequencer_if #(
    parameter int unsigned NumberOfBits = 20
);
    logic                    wall_hit;
    logic                    paddle_hit;
    logic                    score;
    logic                    mute;
    logic [NumberOfBits-1:0] half_period;
    logic                    note_strobe;
    logic                    busy;
    logic [1:0]              active_sound;

    modport master (
        output wall_hit, paddle_hit, score, mute,
        input  half_period, note_strobe, busy, active_sound
    );

    modport slave (
        input  wall_hit, paddle_hit, score, mute,
        output half_period, note_strobe, busy, active_sound
    );
endinterface

// File: rtl/pong_tick_prescaler.sv
// Emits a one-cycle tick every TickDivisor cycles; clear_i restarts the count from zero.
module pong_tick_prescaler #(
    parameter int unsigned TickDivisor = 500000,
    parameter int unsigned TickBits    = 19
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);
    logic [TickBits-1:0] count_q, count_d;

    always_comb begin
        tick_o  = (count_q == TickBits'(TickDivisor - 1));
        count_d = count_q + TickBits'(1);
        if (clear_i || tick_o) count_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/pong_sound_sequencer.sv
// Priority arbiter and note sequencer sharing one square-wave tone generator
// between the wall, paddle and score sound effects.
module pong_sound_sequencer
    import pong_sound_pkg::*;
#(
    parameter int unsigned NumberOfBits = 20,
    parameter int unsigned TickDivisor  = 500000,
    parameter int unsigned TickBits     = 19,
    parameter int unsigned GapTicks     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pong_sound_sequencer_if.slave  bus_io
);
    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e                  state_q, state_d;
    sound_e                  active_q, active_d;
    logic [1:0]              idx_q, idx_d;
    logic [DurBits-1:0]      tick_cnt_q, tick_cnt_d;
    logic [NumberOfBits-1:0] note_q, note_d;
    logic                    strobe_q, strobe_d;
    logic [2:0]              pending_q, pending_d;

    logic                    tick, clear;
    logic [2:0]              req_eff, pend_all;
    sound_e                  req_top, pend_top, start_snd;
    logic [DurBits:0]        tick_next;
    logic [DurBits-1:0]      dur_eff;
    logic                    note_done, gap_done, more_notes;

    pong_tick_prescaler #(
        .TickDivisor (TickDivisor),
        .TickBits    (TickBits)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear),
        .tick_o  (tick)
    );

    always_comb begin
        // A request for the sound already playing is dropped, never retriggered.
        req_eff    = {bus_io.score, bus_io.paddle_hit, bus_io.wall_hit} & ~sound_mask(active_q);
        pend_all   = pending_q | req_eff;
        req_top    = pick_highest(req_eff);
        pend_top   = pick_highest(pend_all);
        tick_next  = {1'b0, tick_cnt_q} + 9'd1;
        dur_eff    = (note_dur(active_q) == '0) ? 8'd1 : note_dur(active_q);
        note_done  = tick && (tick_next >= {1'b0, dur_eff});
        gap_done   = tick && (tick_next >= 9'(GapTicks));
        more_notes = ({1'b0, idx_q} + 3'd1) < {1'b0, note_count(active_q)};

        state_d    = state_q;
        active_d   = active_q;
        idx_d      = idx_q;
        tick_cnt_d = tick_cnt_q;
        note_d     = note_q;
        strobe_d   = 1'b0;
        clear      = 1'b0;
        start_snd  = SndNone;

        case (state_q)
            StIdle: begin
                if (pend_all != 3'b000) start_snd = pend_top;
            end
            StPlay: begin
                if (req_top > active_q) begin
                    start_snd = req_top;
                end else if (note_done) begin
                    tick_cnt_d = '0;
                    clear      = 1'b1;
                    if (more_notes) begin
                        state_d = StGap;
                        idx_d   = idx_q + 2'd1;
                        note_d  = '0;
                    end else if (pend_all != 3'b000) begin
                        start_snd = pend_top;
                    end else begin
                        state_d  = StIdle;
                        active_d = SndNone;
                        idx_d    = '0;
                        note_d   = '0;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_next[DurBits-1:0];
                end
            end
            StGap: begin
                if (req_top > active_q) begin
                    start_snd = req_top;
                end else if (gap_done) begin
                    state_d    = StPlay;
                    tick_cnt_d = '0;
                    clear      = 1'b1;
                    strobe_d   = 1'b1;
                    note_d     = NumberOfBits'(note_half(active_q, idx_q));
                end else if (tick) begin
                    tick_cnt_d = tick_next[DurBits-1:0];
                end
            end
            default: state_d = StIdle;
        endcase

        // Starting a sound (fresh, preempting, or chained) always begins at note 0.
        if (start_snd != SndNone) begin
            state_d    = StPlay;
            active_d   = start_snd;
            idx_d      = '0;
            tick_cnt_d = '0;
            clear      = 1'b1;
            strobe_d   = 1'b1;
            note_d     = NumberOfBits'(note_half(start_snd, 2'd0));
        end
        pending_d = pend_all & ~sound_mask(start_snd);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            active_q   <= SndNone;
            idx_q      <= '0;
            tick_cnt_q <= '0;
            note_q     <= '0;
            strobe_q   <= 1'b0;
            pending_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            idx_q      <= idx_d;
            tick_cnt_q <= tick_cnt_d;
            note_q     <= note_d;
            strobe_q   <= strobe_d;
            pending_q  <= pending_d;
        end
    end

    assign bus_io.half_period  = bus_io.mute ? '0 : note_q;
    assign bus_io.note_strobe  = strobe_q;
    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.active_sound = active_q;
endmodule
